// File: rtl/cache_pkg.sv
// cache_pkg: shared sizes, arbiter state encoding and block-address helpers
package cache_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int BLOCK_BYTES = 2 * BLOCK_WORDS;
  localparam int OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
  typedef enum logic [1:0] {IDLE, STORE, FILL_D, FILL_I} arbState_t;
  function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
  function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] n);
    return base + ADDR_W'({n, 1'b0});
  endfunction
endpackage

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: issues one block of reads and forwards the returning words in order
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rdEn,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              fillWe,
  output logic [ADDR_W-1:0] fillAddr,
  output logic [DATA_W-1:0] fillData,
  output logic              fillDone
);
  logic              busy;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issueCnt, recvCnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      base <= '0;
      issueCnt <= '0;
      recvCnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      base <= blockBase(startAddr);
      issueCnt <= '0;
      recvCnt <= '0;
    end else if (busy) begin
      issueCnt <= issueCnt + CNT_W'(rdEn);
      recvCnt <= recvCnt + CNT_W'(fillWe);
      busy <= !fillDone;
    end
  end
  // returns are accepted only while a fill is live, so stale data after a reset is dropped
  always_comb begin
    rdEn = busy && issueCnt < CNT_W'(BLOCK_WORDS);
    fillWe = busy && mem_data_valid && recvCnt < CNT_W'(BLOCK_WORDS);
    fillDone = fillWe && recvCnt == CNT_W'(BLOCK_WORDS - 1);
    rdAddr = rdEn ? wordAddr(base, issueCnt) : '0;
    fillAddr = fillWe ? wordAddr(base, recvCnt) : '0;
    fillData = fillWe ? mem_rdata : '0;
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I/D block fills and D write-through stores onto one memory port
module cache_mem_arbiter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_store,
  input  logic [ADDR_W-1:0] d_store_addr,
  input  logic [DATA_W-1:0] d_store_data,
  output logic              i_stall,
  output logic              d_stall,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_store_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);
  arbState_t         state, nextState;
  logic              start, rdEn, fillWe, fillDone, isStore;
  logic [ADDR_W-1:0] startAddr, rdAddr;
  cache_fill_fsm u_fill (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .startAddr(startAddr),
    .mem_data_valid(mem_data_valid),
    .mem_rdata(mem_rdata),
    .rdEn(rdEn),
    .rdAddr(rdAddr),
    .fillWe(fillWe),
    .fillAddr(fill_addr),
    .fillData(fill_data),
    .fillDone(fillDone)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  end
  // priority: store > D miss > I miss
  always_comb begin
    nextState = state;
    start = 1'b0;
    startAddr = d_miss_addr;
    unique case (state)
      IDLE: begin
        if (d_store) nextState = STORE;
        else if (d_miss) begin
          nextState = FILL_D;
          start = 1'b1;
        end else if (i_miss) begin
          nextState = FILL_I;
          start = 1'b1;
          startAddr = i_miss_addr;
        end
      end
      STORE: nextState = IDLE;
      default: if (fillDone) nextState = IDLE;
    endcase
  end
  always_comb begin
    isStore = state == STORE;
    mem_en = isStore || rdEn;
    mem_wr = isStore;
    mem_addr = isStore ? d_store_addr : rdAddr;
    mem_wdata = isStore ? d_store_data : '0;
    i_fill_we = state == FILL_I && fillWe;
    d_fill_we = state == FILL_D && fillWe;
    i_fill_done = state == FILL_I && fillDone;
    d_fill_done = state == FILL_D && fillDone;
    d_store_done = isStore;
    i_stall = i_miss && !i_fill_done;
    d_stall = (d_miss && !d_fill_done) || (d_store && !d_store_done);
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios against a transaction-level model plus a latency-driven memory
module tb_cache_mem_arbiter;
  localparam int LAT = 4;
  localparam int BW = 8;
  logic clk = 1'b0;
  logic rst_n, i_miss, d_miss, d_store, mem_data_valid;
  logic [15:0] i_miss_addr, d_miss_addr, d_store_addr, d_store_data, mem_rdata;
  logic i_stall, d_stall, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_store_done, mem_en, mem_wr;
  logic [15:0] fill_addr, fill_data, mem_addr, mem_wdata;
  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_store(d_store), .d_store_addr(d_store_addr), .d_store_data(d_store_data),
    .i_stall(i_stall), .d_stall(d_stall),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_store_done(d_store_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction
  typedef struct { int due; logic [15:0] addr; } rd_t;
  rd_t pend[$];
  bit gapMode = 0;
  int lastDue = 0;
  bit chkOn = 0;
  // memory: returns reads in order, LAT cycles after issue plus optional gaps
  initial begin
    mem_data_valid = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_data_valid = 1;
        mem_rdata = memWord(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_data_valid = 0;
        mem_rdata = 0;
      end
    end
  end
  int rdN, firstRdCyc, lastRdCyc, iWeN, dWeN, firstWeCyc, doneN, storeN, vN;
  logic [15:0] firstRdAddr, lastRdAddr, lastFillAddr, storeAddr, storeData;
  task automatic clrMon();
    rdN = 0; iWeN = 0; dWeN = 0; doneN = 0; storeN = 0; vN = 0;
    firstRdCyc = -1; lastRdCyc = -1; firstWeCyc = -1;
    firstRdAddr = 0; lastRdAddr = 0; lastFillAddr = 0; storeAddr = 0; storeData = 0;
  endtask
  // model: side 0 idle, 1 store, 2 D fill, 3 I fill; words issued/received count block progress
  int mSide = 0, mIss = 0, mRcv = 0;
  logic [15:0] mBase = 0;
  initial begin
    logic eStore, eRd, eWe, eDone;
    logic [15:0] eFa;
    rd_t r;
    forever begin
      @(negedge clk);
      if (chkOn) begin
        eStore = mSide == 1;
        eRd = mSide >= 2 && mIss < BW;
        eWe = mSide >= 2 && mem_data_valid;
        eFa = eWe ? 16'(mBase + 16'(2 * mRcv)) : 16'h0;
        eDone = eWe && mRcv == BW - 1;
        chk("mem_en", mem_en, eStore | eRd);
        chk("mem_wr", mem_wr, eStore);
        chk("mem_addr", mem_addr, eStore ? d_store_addr : eRd ? 16'(mBase + 16'(2 * mIss)) : 16'h0);
        chk("mem_wdata", mem_wdata, eStore ? d_store_data : 16'h0);
        chk("i_fill_we", i_fill_we, eWe && mSide == 3);
        chk("d_fill_we", d_fill_we, eWe && mSide == 2);
        chk("fill_addr", fill_addr, eFa);
        chk("fill_data", fill_data, eWe ? memWord(eFa) : 16'h0);
        chk("i_fill_done", i_fill_done, eDone && mSide == 3);
        chk("d_fill_done", d_fill_done, eDone && mSide == 2);
        chk("d_store_done", d_store_done, eStore);
        chk("i_stall", i_stall, i_miss && !(eDone && mSide == 3));
        chk("d_stall", d_stall, (d_miss && !(eDone && mSide == 2)) || (d_store && !eStore));
        if (!rst_n) begin
          mSide = 0; mIss = 0; mRcv = 0;
        end else if (mSide == 0) begin
          mIss = 0; mRcv = 0;
          if (d_store) mSide = 1;
          else if (d_miss) begin mSide = 2; mBase = d_miss_addr & 16'hFFF0; end
          else if (i_miss) begin mSide = 3; mBase = i_miss_addr & 16'hFFF0; end
        end else if (mSide == 1) mSide = 0;
        else begin
          mIss += int'(eRd);
          mRcv += int'(eWe);
          if (eDone) mSide = 0;
        end
        if (mem_en && !mem_wr) begin
          r.addr = mem_addr;
          r.due = cyc + LAT + (gapMode ? int'($urandom_range(0, 2)) : 0);
          if (r.due <= lastDue) r.due = lastDue + 1;
          lastDue = r.due;
          pend.push_back(r);
          if (rdN == 0) begin firstRdCyc = cyc; firstRdAddr = mem_addr; end
          rdN++;
          lastRdCyc = cyc;
          lastRdAddr = mem_addr;
        end
        if (mem_en && mem_wr) begin storeN++; storeAddr = mem_addr; storeData = mem_wdata; end
        if (mem_data_valid) vN++;
        if (i_fill_we || d_fill_we) begin
          if (firstWeCyc < 0) firstWeCyc = cyc;
          lastFillAddr = fill_addr;
        end
        iWeN += int'(i_fill_we);
        dWeN += int'(d_fill_we);
        doneN += int'(i_fill_done) + int'(d_fill_done);
      end
    end
  end
  task automatic waitDone(input int side, input int maxC, output int at);
    at = -1;
    for (int k = 0; k < maxC; k++) begin
      @(negedge clk);
      if (side == 0 ? i_fill_done : side == 1 ? d_fill_done : d_store_done) begin
        at = cyc;
        break;
      end
    end
    chk("done_within_bound", at >= 0, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  int c0, at;
  initial begin
    rst_n = 0; i_miss = 0; d_miss = 0; d_store = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_store_addr = 0; d_store_data = 0;
    clrMon();
    @(posedge clk); #1 chkOn = 1;
    @(negedge clk);
    chk("reset_outs", {mem_en, mem_wr, i_stall, d_stall, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_store_done, fill_addr, mem_addr}, 0);
    @(posedge clk); #1 rst_n = 1;
    // single I fill
    @(posedge clk); #1 clrMon(); i_miss = 1; i_miss_addr = 16'h0036; c0 = cyc;
    waitDone(0, 40, at);
    chk("t1_done_cyc", at - c0, 12);
    chk("t1_istall_at_done", i_stall, 0);
    @(posedge clk); #1 i_miss = 0;
    chk("t1_reads", rdN, 8);
    chk("t1_first_rd_cyc", firstRdCyc - c0, 1);
    chk("t1_last_rd_cyc", lastRdCyc - c0, 8);
    chk("t1_first_rd_addr", firstRdAddr, 16'h0030);
    chk("t1_last_rd_addr", lastRdAddr, 16'h003E);
    chk("t1_we_count", iWeN, 8);
    chk("t1_first_we_cyc", firstWeCyc - c0, 5);
    // simultaneous D and I miss
    @(posedge clk); #1 clrMon(); i_miss = 1; i_miss_addr = 16'h0100; d_miss = 1; d_miss_addr = 16'h0208; c0 = cyc;
    waitDone(1, 40, at);
    chk("t2_d_done_cyc", at - c0, 12);
    chk("t2_istall_held", i_stall, 1);
    @(posedge clk); #1 d_miss = 0;
    chk("t2_no_i_we_yet", iWeN, 0);
    chk("t2_d_we_count", dWeN, 8);
    clrMon();
    waitDone(0, 40, at);
    chk("t2_i_done_cyc", at - c0, 25);
    @(posedge clk); #1 i_miss = 0;
    chk("t2_i_first_rd_cyc", firstRdCyc - c0, 14);
    chk("t2_i_first_rd_addr", firstRdAddr, 16'h0100);
    chk("t2_i_we_count", iWeN, 8);
    // store arriving during an I fill
    @(posedge clk); #1 clrMon(); i_miss = 1; i_miss_addr = 16'h0040; c0 = cyc;
    repeat (3) @(posedge clk);
    #1 d_store = 1; d_store_addr = 16'h1002; d_store_data = 16'hBEEF;
    waitDone(0, 40, at);
    chk("t3_i_done_cyc", at - c0, 12);
    chk("t3_dstall_waiting", d_stall, 1);
    chk("t3_no_store_yet", storeN, 0);
    @(posedge clk); #1 i_miss = 0;
    waitDone(2, 10, at);
    chk("t3_store_cyc", at - c0, 14);
    @(posedge clk); #1 d_store = 0;
    chk("t3_store_count", storeN, 1);
    chk("t3_store_addr", storeAddr, 16'h1002);
    chk("t3_store_data", storeData, 16'hBEEF);
    chk("t3_i_we_count", iWeN, 8);
    // reset in the middle of a fill
    @(posedge clk); #1 clrMon(); i_miss = 1; i_miss_addr = 16'h0080; c0 = cyc;
    repeat (7) @(posedge clk);
    #1 rst_n = 0; i_miss = 0;
    @(posedge clk); #1 rst_n = 1; clrMon();
    @(negedge clk);
    chk("t4_outs_after_reset", {mem_en, mem_wr, i_stall, d_stall, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_store_done, fill_addr, mem_addr}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_stale_valids", vN, 4);
    chk("t4_no_fill_we", iWeN + dWeN, 0);
    chk("t4_no_done", doneN, 0);
    chk("t4_mem_drained", pend.size(), 0);
    // D fill at top of address space
    clrMon(); d_miss = 1; d_miss_addr = 16'hFFF8; c0 = cyc;
    waitDone(1, 40, at);
    chk("t5_done_cyc", at - c0, 12);
    @(posedge clk); #1 d_miss = 0;
    chk("t5_first_rd_addr", firstRdAddr, 16'hFFF0);
    chk("t5_last_rd_addr", lastRdAddr, 16'hFFFE);
    chk("t5_last_fill_addr", lastFillAddr, 16'hFFFE);
    chk("t5_we_count", dWeN, 8);
    // irregular memory return timing
    @(posedge clk); #1 gapMode = 1; clrMon(); i_miss = 1; i_miss_addr = 16'h1234;
    waitDone(0, 80, at);
    @(posedge clk); #1 i_miss = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_we_count", iWeN, 8);
    chk("t6_done_count", doneN, 1);
    chk("t6_first_rd_addr", firstRdAddr, 16'h1230);
    chk("t6_last_fill_addr", lastFillAddr, 16'h123E);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
